// File: rtl/pc_unit.sv
// Program counter for the fetch stage: inc, jump, signed branch, call/return
// through an internal return-address stack, stall, and sticky error flags.
module pc_unit #(
  parameter int unsigned       ADDR_W      = 24,
  parameter int unsigned       OFF_W       = 12,
  parameter int unsigned       STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic [2:0]                     op,
  input  logic [ADDR_W-1:0]              target,
  input  logic [OFF_W-1:0]               offset,
  input  logic                           br_take,
  input  logic                           err_clr,
  output logic [ADDR_W-1:0]              pc_out,
  output logic                           redirect,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           stack_full,
  output logic                           stack_empty,
  output logic                           err_ovf,
  output logic                           err_udf,
  output logic                           err_ill
);

  localparam int unsigned PTR_W   = $clog2(STACK_DEPTH);
  localparam int unsigned DEPTH_W = PTR_W + 1;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               redirect_q, redirect_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_udf_q, err_udf_d;
  logic               err_ill_q, err_ill_d;
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

  logic               push_c;
  logic               full_c, empty_c;
  logic               ovf_set_c, udf_set_c, ill_set_c;
  logic [ADDR_W-1:0]  pc_inc_c;
  logic [ADDR_W-1:0]  off_ext_c;
  logic [PTR_W-1:0]   push_idx_c, pop_idx_c;

  assign full_c     = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty_c    = (depth_q == '0);
  assign pc_inc_c   = pc_q + ADDR_W'(1);
  assign off_ext_c  = ADDR_W'($signed(offset));
  assign push_idx_c = depth_q[PTR_W-1:0];
  assign pop_idx_c  = PTR_W'(depth_q - DEPTH_W'(1));

  // Next-state decode; stall freezes everything except error clearing
  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    depth_d    = depth_q;
    push_c     = 1'b0;
    ovf_set_c  = 1'b0;
    udf_set_c  = 1'b0;
    ill_set_c  = 1'b0;
    if (!stall) begin
      case (op)
        OP_HOLD: pc_d = pc_q;
        OP_INC:  pc_d = pc_inc_c;
        OP_JUMP: begin
          pc_d       = target;
          redirect_d = 1'b1;
        end
        OP_BRANCH: begin
          if (br_take) begin
            pc_d       = pc_q + off_ext_c;
            redirect_d = 1'b1;
          end else begin
            pc_d = pc_inc_c;
          end
        end
        OP_CALL: begin
          if (full_c) begin
            ovf_set_c = 1'b1;
          end else begin
            push_c     = 1'b1;
            depth_d    = depth_q + DEPTH_W'(1);
            pc_d       = target;
            redirect_d = 1'b1;
          end
        end
        OP_RET: begin
          if (empty_c) begin
            udf_set_c = 1'b1;
          end else begin
            depth_d    = depth_q - DEPTH_W'(1);
            pc_d       = stack_q[pop_idx_c];
            redirect_d = 1'b1;
          end
        end
        default: ill_set_c = 1'b1;
      endcase
    end
    // A new error in the same cycle as err_clr stays set
    err_ovf_d = (err_ovf_q & ~err_clr) | ovf_set_c;
    err_udf_d = (err_udf_q & ~err_clr) | udf_set_c;
    err_ill_d = (err_ill_q & ~err_clr) | ill_set_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      redirect_q <= 1'b0;
      depth_q    <= '0;
      err_ovf_q  <= 1'b0;
      err_udf_q  <= 1'b0;
      err_ill_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      depth_q    <= depth_d;
      err_ovf_q  <= err_ovf_d;
      err_udf_q  <= err_udf_d;
      err_ill_q  <= err_ill_d;
    end
  end

  // Stack contents need no reset; depth_q alone defines which entries are valid
  always_ff @(posedge clk) begin
    if (push_c) begin
      stack_q[push_idx_c] <= pc_inc_c;
    end
  end

  assign pc_out      = pc_q;
  assign redirect    = redirect_q;
  assign depth       = depth_q;
  assign stack_full  = full_c;
  assign stack_empty = empty_c;
  assign err_ovf     = err_ovf_q;
  assign err_udf     = err_udf_q;
  assign err_ill     = err_ill_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a behavioural model queues the expected state
// for each driven cycle, compared one cycle later against the DUT.
module tb_pc_unit;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned OFF_W  = 12;
  localparam int unsigned SDEP   = 8;

  typedef struct {
    logic [23:0] pc;
    logic        red;
    int          depth;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        udf;
    logic        ill;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic [2:0]        op;
  logic [23:0]       target;
  logic [11:0]       offset;
  logic              br_take;
  logic              err_clr;
  logic [23:0]       pc_out;
  logic              redirect;
  logic [3:0]        depth;
  logic              stack_full, stack_empty;
  logic              err_ovf, err_udf, err_ill;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        sb [$];
  logic [23:0] m_pc;
  logic [23:0] m_stack [$];
  logic        m_ovf, m_udf, m_ill;

  pc_unit #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .STACK_DEPTH(SDEP), .RESET_VEC(24'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .target(target), .offset(offset),
    .br_take(br_take), .err_clr(err_clr), .pc_out(pc_out), .redirect(redirect),
    .depth(depth), .stack_full(stack_full), .stack_empty(stack_empty),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_ill(err_ill)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_pc = 24'h0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_ill = 1'b0;
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, ".pc"},    32'(pc_out),      32'(e.pc));
    check({tag, ".red"},   32'(redirect),    32'(e.red));
    check({tag, ".depth"}, 32'(depth),       32'(e.depth));
    check({tag, ".full"},  32'(stack_full),  32'(e.full));
    check({tag, ".empty"}, 32'(stack_empty), 32'(e.empty));
    check({tag, ".ovf"},   32'(err_ovf),     32'(e.ovf));
    check({tag, ".udf"},   32'(err_udf),     32'(e.udf));
    check({tag, ".ill"},   32'(err_ill),     32'(e.ill));
  endtask

  // Drive one cycle, predict its result, then compare after the edge
  task automatic step(input string tag, input logic s, input logic [2:0] o,
                      input logic [23:0] t, input logic [11:0] off,
                      input logic bt, input logic ec);
    exp_t e;
    logic red, so, su, si;
    logic [23:0] sext;
    @(negedge clk);
    stall = s; op = o; target = t; offset = off; br_take = bt; err_clr = ec;
    red = 1'b0; so = 1'b0; su = 1'b0; si = 1'b0;
    sext = {{12{off[11]}}, off};
    if (!s) begin
      case (o)
        3'd1: m_pc = m_pc + 24'd1;
        3'd2: begin m_pc = t; red = 1'b1; end
        3'd3: if (bt) begin m_pc = m_pc + sext; red = 1'b1; end
              else m_pc = m_pc + 24'd1;
        3'd4: if (m_stack.size() == SDEP) so = 1'b1;
              else begin m_stack.push_back(m_pc + 24'd1); m_pc = t; red = 1'b1; end
        3'd5: if (m_stack.size() == 0) su = 1'b1;
              else begin m_pc = m_stack.pop_back(); red = 1'b1; end
        3'd6, 3'd7: si = 1'b1;
        default: ;
      endcase
    end
    m_ovf = (m_ovf && !ec) || so;
    m_udf = (m_udf && !ec) || su;
    m_ill = (m_ill && !ec) || si;
    e.pc = m_pc; e.red = red; e.depth = m_stack.size();
    e.full = (m_stack.size() == SDEP); e.empty = (m_stack.size() == 0);
    e.ovf = m_ovf; e.udf = m_udf; e.ill = m_ill;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      compare_all(tag, e);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; op = 3'd0; target = '0; offset = '0;
    br_take = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.pc", 32'(pc_out), 32'h0);
    check("rst.red", 32'(redirect), 32'h0);
    check("rst.depth", 32'(depth), 32'h0);
    check("rst.empty", 32'(stack_empty), 32'h1);
    check("rst.full", 32'(stack_full), 32'h0);
    check("rst.errs", 32'({err_ovf, err_udf, err_ill}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Run a bit, then assert reset mid-cycle: pc must clear without a clock edge
    for (int i = 0; i < 3; i++) step("pre_inc", 0, 3'd1, 0, 0, 0, 0);
    step("pre_call", 0, 3'd4, 24'h40, 0, 0, 0);
    @(negedge clk);
    op = 3'd0;
    #2 rst = 1'b1;
    #1;
    check("async_rst.pc", 32'(pc_out), 32'h0);
    check("async_rst.depth", 32'(depth), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 5; i++) step("inc", 0, 3'd1, 0, 0, 0, 0);
    check("inc5.pc", 32'(pc_out), 32'h5);

    step("jump_max", 0, 3'd2, 24'hFFFFFF, 0, 0, 0);
    step("wrap", 0, 3'd1, 0, 0, 0, 0);
    check("wrap.pc", 32'(pc_out), 32'h0);

    step("jump100", 0, 3'd2, 24'h000100, 0, 0, 0);
    step("br_take", 0, 3'd3, 0, 12'hFF0, 1, 0);
    check("br_take.pc", 32'(pc_out), 32'h0000F0);
    step("br_after", 0, 3'd0, 0, 0, 0, 0);
    step("jump100b", 0, 3'd2, 24'h000100, 0, 0, 0);
    step("br_not", 0, 3'd3, 0, 12'hFF0, 0, 0);
    check("br_not.pc", 32'(pc_out), 32'h000101);
    step("br_min", 0, 3'd3, 0, 12'h800, 1, 0);
    step("br_pos", 0, 3'd3, 0, 12'h7FF, 1, 0);
    step("jump_self", 0, 3'd2, pc_out + 24'd1, 0, 0, 0);

    step("j10", 0, 3'd2, 24'h10, 0, 0, 0);
    step("call200", 0, 3'd4, 24'h200, 0, 0, 0);
    step("call300", 0, 3'd4, 24'h300, 0, 0, 0);
    check("nest.depth", 32'(depth), 32'h2);
    step("ret1", 0, 3'd5, 0, 0, 0, 0);
    check("ret1.pc", 32'(pc_out), 32'h201);
    step("ret2", 0, 3'd5, 0, 0, 0, 0);
    check("ret2.pc", 32'(pc_out), 32'h11);
    check("ret2.empty", 32'(stack_empty), 32'h1);

    for (int i = 0; i < 8; i++) step("fill", 0, 3'd4, 24'h1000 + 24'(i * 16), 0, 0, 0);
    check("fill.full", 32'(stack_full), 32'h1);
    step("call_ovf", 0, 3'd4, 24'h5555, 0, 0, 0);
    check("ovf.flag", 32'(err_ovf), 32'h1);
    check("ovf.depth", 32'(depth), 32'h8);
    step("clr_ovf", 0, 3'd0, 0, 0, 0, 1);
    check("clr_ovf.flag", 32'(err_ovf), 32'h0);
    for (int i = 0; i < 8; i++) step("drain", 0, 3'd5, 0, 0, 0, 0);

    step("ret_udf", 0, 3'd5, 0, 0, 0, 0);
    check("udf.flag", 32'(err_udf), 32'h1);
    step("ill7", 0, 3'd7, 0, 0, 0, 0);
    check("ill.flag", 32'(err_ill), 32'h1);
    step("clr_ill6", 0, 3'd6, 0, 0, 0, 1);
    check("clr_set.ill", 32'(err_ill), 32'h1);
    step("clr_all", 0, 3'd0, 0, 0, 0, 1);

    step("stall_call", 1, 3'd4, 24'h777, 0, 0, 0);
    step("stall_ill_clr", 1, 3'd7, 0, 0, 0, 0);
    step("unstall_call", 0, 3'd4, 24'h777, 0, 0, 0);
    check("unstall.pc", 32'(pc_out), 32'h777);
    step("stall_errclr", 1, 3'd6, 0, 0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      step("rand", 1'($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
           24'($urandom), 12'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
    end

    check("sb.drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program counter: the next generation of the core's sequential PC. It adds absolute jump, signed relative branch, call/return with an internal return-address stack, a stall input, and error flags. It sits at the front of the fetch stage, drives the instruction memory address, and gives the pipeline a one-cycle redirect pulse for flush.

Parameters:
ADDR_W, 24, PC width in bits. All PC arithmetic is modulo 2^ADDR_W.
OFF_W, 12, width of the signed branch offset. Legal range 2..ADDR_W.
STACK_DEPTH, 8, return-address stack entries. Must be a power of two, at least 2.
RESET_VEC, 0, PC value loaded on reset (ADDR_W bits).

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
stall  input  1  freeze: overrides op, no state change
op  input  3  000 hold, 001 inc, 010 jump, 011 branch, 100 call, 101 return, 110/111 illegal
target  input  ADDR_W  absolute destination for jump and call
offset  input  OFF_W  signed two's-complement branch offset
br_take  input  1  branch condition, sampled only when op=011
err_clr  input  1  clears all sticky error flags
pc_out  output  ADDR_W  current PC
redirect  output  1  one-cycle pulse, set the cycle after a non-sequential PC update
depth  output  $clog2(STACK_DEPTH)+1  number of valid stack entries
stack_full  output  1  depth==STACK_DEPTH
stack_empty  output  1  depth==0
err_ovf  output  1  sticky: call attempted while stack full
err_udf  output  1  sticky: return attempted while stack empty
err_ill  output  1  sticky: illegal op decoded

Behaviour:
- Reset (async, takes effect immediately): pc_out=RESET_VEC, redirect=0, depth=0, stack_empty=1, stack_full=0, all err_*=0. Stack contents are don't-care. Reset mid-operation discards any pending push or pop.
- All updates happen on the rising clk edge. The new pc_out is visible the cycle after op is presented (latency 1). stack_full and stack_empty are combinational from depth.
- stall=1: pc_out, stack, depth and err_* hold. redirect=0. err_clr is still honoured.
- stall=0, by op:
  - hold: pc_out holds. redirect=0.
  - inc: pc_out+1, wrapping from 2^ADDR_W-1 to 0. redirect=0.
  - jump: pc_out=target. redirect=1.
  - branch with br_take=1: pc_out = pc_out + sign_extend(offset), truncated to ADDR_W. redirect=1.
  - branch with br_take=0: behaves as inc. redirect=0.
  - call, not full: push (pc_out+1, wrapped), depth+1, pc_out=target, redirect=1.
  - call, full: no push, pc_out holds, err_ovf=1, redirect=0.
  - return, not empty: pop the top entry into pc_out, depth-1, redirect=1.
  - return, empty: pc_out holds, err_udf=1, redirect=0.
  - 110/111: pc_out holds, err_ill=1, redirect=0.
- redirect is a registered output. It is 1 only in the cycle following an accepted non-sequential update, even if that update's target equals pc_out+1.
- Stack is LIFO, implemented as a register array with a top pointer. Push and pop never occur in the same cycle.
- err_clr=1 clears err_* that cycle. If an error condition occurs in the same cycle, set wins.
- Default config, sign extension: offset 12'hFFF means -1; 12'h800 means -2048.

Test Plan:
- Reset/inc: assert rst mid-run -> pc_out=0 immediately. Then op=inc ×5 -> pc_out=5, redirect stays 0.
- Wrap and branch: force pc_out=24'hFFFFFF via jump, then inc -> 0. From pc=0x000100, branch with offset=12'hFF0 and br_take=1 -> 0x0000F0, redirect=1 for exactly one cycle. Same op with br_take=0 -> 0x000101.
- Call/return nesting: from pc=0x10, call target=0x200, then call target=0x300 -> depth=2. Return -> pc=0x201. Return -> pc=0x11, stack_empty=1.
- Overflow: 8 calls -> stack_full=1. 9th call -> pc holds, err_ovf=1, depth=8. err_clr -> err_ovf=0.
- Underflow/illegal: return on empty stack -> err_udf=1, pc holds. op=3'b111 -> err_ill=1. err_clr in the same cycle as a new illegal op -> err_ill stays 1.
- Stall: stall=1 with op=call -> pc, depth and redirect unchanged. Deassert stall -> call executes next edge.
